// File: rtl/srl_iter_pkg.sv
// Shared definitions for the iterative right shifter: default widths,
// FSM state encoding and a helper sizing the stage counter.
// No ports; imported by srl_stage and srl_iter.
package srl_iter_pkg;

    localparam int SRL_DATA_W  = 32;
    localparam int SRL_SHAMT_W = 5;

    typedef enum logic [1:0] {
        SRL_IDLE  = 2'd0,
        SRL_SHIFT = 2'd1,
        SRL_DONE  = 2'd2
    } srl_state_e;

    // Width of a counter that indexes stages 0..shamt_w-1 (at least one bit).
    function automatic int srl_stg_w(input int shamt_w);
        return (shamt_w > 1) ? $clog2(shamt_w) : 1;
    endfunction

endpackage

// File: rtl/srl_stage.sv
// One shared right-shift rank: shifts data by 1<<stage_i when en_i is set,
// filling vacated MSBs with fill_i; passes data through otherwise.
// Ports: data_i/data_o (DATA_W), fill_i, stage_i (stage index), en_i. Purely combinational.
module srl_stage
    import srl_iter_pkg::*;
#(
    parameter int DATA_W  = SRL_DATA_W,
    parameter int SHAMT_W = SRL_SHAMT_W,
    parameter int STG_W   = srl_stg_w(SHAMT_W)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              fill_i,
    input  logic [STG_W-1:0]  stage_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] data_o
);

    // Every candidate shift distance is a fixed wiring pattern; the stage
    // index only picks one of them, so a single mux rank serves all stages.
    logic [DATA_W-1:0] cand [SHAMT_W];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_cand
        assign cand[k] = {{(1 << k){fill_i}}, data_i[DATA_W-1:(1 << k)]};
    end

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                if (stage_i == k[STG_W-1:0]) begin
                    data_o = cand[k];
                end
            end
        end
    end

endmodule

// File: rtl/srl_iter.sv
// Sequential logical/arithmetic right shifter: resolves one shift-amount bit
// per clock through a shared srl_stage rank, valid/ready on both sides.
// Ports: clk, rst (async active-high); in_valid/in_ready with a, movement
// (low SHAMT_W bits used), arith; out/out_valid/out_ready.
// Latency: SHAMT_W+1 edges from accept to out_valid; DONE holds while out_ready is low.
// Optional: SRL_ITER_SRA_EN enables sign fill via arith; without it arith is ignored.
module srl_iter
    import srl_iter_pkg::*;
#(
    parameter int DATA_W  = SRL_DATA_W,
    parameter int SHAMT_W = SRL_SHAMT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [31:0]       movement,
    input  logic              arith,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int STG_W = srl_stg_w(SHAMT_W);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(SHAMT_W - 1);

    srl_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [SHAMT_W-1:0] amt_q,  amt_d;
    logic [STG_W-1:0]  stg_q,   stg_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              fill;
    logic [DATA_W-1:0] stage_out;

    // Bits of the amount field above SHAMT_W never affect the result.
    logic unused_in;

`ifdef SRL_ITER_SRA_EN
    logic fill_q, fill_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (state_q == SRL_IDLE && in_valid) begin
            fill_d = arith & a[DATA_W-1];
        end
    end

    assign fill      = fill_q;
    assign unused_in = ^movement[31:SHAMT_W];
`else
    assign fill      = 1'b0;
    assign unused_in = arith ^ (^movement[31:SHAMT_W]);
`endif

    srl_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .STG_W   (STG_W)
    ) u_stage (
        .data_i  (data_q),
        .fill_i  (fill),
        .stage_i (stg_q),
        .en_i    (amt_q[stg_q]),
        .data_o  (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SRL_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            stg_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            stg_q   <= stg_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        amt_d     = amt_q;
        stg_d     = stg_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            SRL_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = a;
                    amt_d   = movement[SHAMT_W-1:0];
                    stg_d   = '0;
                    state_d = SRL_SHIFT;
                end
            end
            SRL_SHIFT: begin
                data_d = stage_out;
                stg_d  = stg_q + 1'b1;
                // The last stage's result goes straight to out so DONE
                // can present it on the very next cycle.
                if (stg_q == LAST_STG) begin
                    out_d   = stage_out;
                    stg_d   = '0;
                    state_d = SRL_DONE;
                end
            end
            SRL_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = SRL_IDLE;
                end
            end
            default: begin
                state_d = SRL_IDLE;
            end
        endcase
    end

    assign out = out_q;

endmodule

// File: tb/tb_srl_iter.sv
module tb_srl_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] movement = '0;
    logic        arith = 1'b0;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    srl_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .movement  (movement),
        .arith     (arith),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Counts handshakes actually taken at each rising edge.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

`ifdef SRL_ITER_SRA_EN
    localparam bit SRA = 1'b1;
`else
    localparam bit SRA = 1'b0;
`endif

    // Reference: shift by the low five amount bits, sign-fill only when
    // arithmetic mode is built in and requested.
    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mmv, input logic mar);
        int unsigned n;
        logic [31:0] ones;
        logic [31:0] r;
        n    = mmv % 32;
        ones = 32'hFFFF_FFFF;
        r    = ma >> n;
        if (SRA && mar && ma[31]) r = r | ~(ones >> n);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE back to IDLE, with `hold` cycles of
    // out_ready low while the result is presented.
    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tmv,
                          input logic tar, input int hold, input logic [31:0] exp);
        int k;
        logic [31:0] held;
        a = ta; movement = tmv; arith = tar; in_valid = 1'b1;
        chk({nm, "/rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        chk({nm, "/lat"}, 32'(k), 32'd6);
        chk({nm, "/out"}, out, exp);
        held = out;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({nm, "/hold"}, {out_valid, in_ready, 30'd0} ^ out ^ held, 32'h8000_0000);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, "/idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] ta;
        logic [31:0] tmv;
        logic        tar;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{32'h8000_0000, 32'd31,          1'b0, 32'h0000_0001};
        vecs[1] = '{32'h8000_0000, 32'd4,           1'b1, SRA ? 32'hF800_0000 : 32'h0800_0000};
        vecs[2] = '{32'h1234_5678, 32'h0000_0020,   1'b0, 32'h1234_5678};
        vecs[3] = '{32'hDEAD_BEEF, 32'd8,           1'b0, 32'h00DE_ADBE};
        vecs[4] = '{32'h0000_00F0, 32'd4,           1'b0, 32'h0000_000F};
        vecs[5] = '{32'h0000_FF00, 32'd8,           1'b0, 32'h0000_00FF};
        vecs[6] = '{32'h8000_0000, 32'd31,          1'b1, SRA ? 32'hFFFF_FFFF : 32'h0000_0001};
        vecs[7] = '{32'h7FFF_FFFF, 32'd31,          1'b1, 32'h0000_0000};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFE1,   1'b1, SRA ? 32'hFFFF_FFFF : 32'h7FFF_FFFF};
        vecs[9] = '{32'h8765_4321, 32'd16,          1'b1, SRA ? 32'hFFFF_8765 : 32'h0000_8765};

        // Reset state
        #12;
        chk("reset/rdy",   32'(in_ready),  32'd1);
        chk("reset/vld",   32'(out_valid), 32'd0);
        chk("reset/out",   out,            32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset in the middle of SHIFT
        a = 32'hFFFF_0000; movement = 32'd3; arith = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst/vld", 32'(out_valid), 32'd0);
        chk("midrst/rdy", 32'(in_ready),  32'd1);
        chk("midrst/out", out,            32'd0);
        #2;
        rst = 1'b0;
        step();
        run_op("after_rst", 32'hFFFF_0000, 32'd3, 1'b0, 0, 32'h1FFF_E000);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ta, vecs[i].tmv, vecs[i].tar, 0, vecs[i].exp);
        end

        // Back-pressure for 10 cycles
        run_op("bp", 32'hDEAD_BEEF, 32'd8, 1'b0, 10, 32'h00DE_ADBE);

        // Back-to-back with in_valid held high and out_ready high
        begin
            int acc0;
            int seen;
            int t_first;
            int t;
            logic [31:0] res [2];
            acc0 = acc_cnt;
            seen = 0;
            t_first = 0;
            t = 0;
            a = 32'h0000_00F0; movement = 32'd4; arith = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
            while (seen < 2 && t < 40) begin
                step();
                t++;
                if (out_valid) begin
                    res[seen] = out;
                    if (seen == 0) begin
                        t_first = t;
                        a = 32'h0000_FF00; movement = 32'd8;
                    end else begin
                        in_valid = 1'b0;
                        chk("b2b/period", 32'(t - t_first), 32'd7);
                    end
                    seen++;
                end
            end
            chk("b2b/count", 32'(seen), 32'd2);
            step();
            step();
            out_ready = 1'b0;
            chk("b2b/res0", res[0], 32'h0000_000F);
            chk("b2b/res1", res[1], 32'h0000_00FF);
            chk("b2b/accepts", 32'(acc_cnt - acc0), 32'd2);
            chk("b2b/idle", {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra;
            logic [31:0] rm;
            logic        rr;
            ra = $urandom;
            rm = $urandom;
            rr = 1'($urandom_range(1, 0));
            run_op("rand", ra, rm, rr, int'($urandom_range(2, 0)), model(ra, rm, rr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
